// File: rtl/fibb_scan_ctrl.sv
// Sequencer that time-shares one 4-bit fibbinary checker across the
// nibbles of a wider word, MSB nibble first, with start/done handshake.
module fibb_scan_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [4*NIBBLES-1:0]         word_in,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLES-1:0]           nib_mask,
  output logic [$clog2(NIBBLES+1)-1:0] nib_count,
  output logic                         word_ok,
  output logic                         chk_a,
  output logic                         chk_b,
  output logic                         chk_c,
  output logic                         chk_d,
  input  logic                         chk_f
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam int CW = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t               state;
  logic [W-1:0]         word;
  logic [IW-1:0]        idx;
  logic [NIBBLES-1:0]   acc_mask;
  logic [CW-1:0]        acc_count;
  logic                 bnd_ok;

  logic [3:0]           nib;
  logic [NIBBLES-1:0]   bnd_vec;
  logic [NIBBLES-1:0]   mask_nxt;
  logic [CW-1:0]        count_nxt;
  logic                 bnd_nxt;

  // bnd_vec[i]: LSB of nibble i+1 and MSB of nibble i are both set
  always_comb begin
    bnd_vec = '0;
    for (int i = 0; i < NIBBLES - 1; i++) begin
      bnd_vec[i] = word[4*i+4] & word[4*i+3];
    end
  end

  always_comb begin
    nib           = word[{idx, 2'b00} +: 4];
    mask_nxt      = acc_mask;
    mask_nxt[idx] = chk_f;
    count_nxt     = acc_count + CW'(chk_f);
    bnd_nxt       = bnd_ok & ~bnd_vec[idx];
  end

  assign busy = (state == SCAN);
  assign done = (state == DONE);
  assign {chk_a, chk_b, chk_c, chk_d} = busy ? nib : 4'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      word      <= '0;
      idx       <= '0;
      acc_mask  <= '0;
      acc_count <= '0;
      bnd_ok    <= 1'b0;
      nib_mask  <= '0;
      nib_count <= '0;
      word_ok   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            word      <= word_in;
            idx       <= IW'(NIBBLES - 1);
            acc_mask  <= '0;
            acc_count <= '0;
            bnd_ok    <= 1'b1;
            state     <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          acc_mask  <= mask_nxt;
          acc_count <= count_nxt;
          bnd_ok    <= bnd_nxt;
          if (idx == '0) begin
            nib_mask  <= mask_nxt;
            nib_count <= count_nxt;
            word_ok   <= (&mask_nxt) & bnd_nxt;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fibb_scan_ctrl.sv
// Randomized self-checking bench for fibb_scan_ctrl (NIBBLES=4) with a
// behavioural fibbinary checker and a word-level reference model.
module tb_fibb_scan_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] word_in;
  logic        busy;
  logic        done;
  logic [3:0]  nib_mask;
  logic [2:0]  nib_count;
  logic        word_ok;
  logic        chk_a;
  logic        chk_b;
  logic        chk_c;
  logic        chk_d;
  logic        chk_f;

  int checks = 0;
  int errors = 0;

  logic [3:0] held_mask;
  logic [2:0] held_count;
  logic       held_ok;

  always #5 clk = ~clk;

  fibb_scan_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .word_in(word_in),
    .busy(busy), .done(done), .nib_mask(nib_mask),
    .nib_count(nib_count), .word_ok(word_ok),
    .chk_a(chk_a), .chk_b(chk_b), .chk_c(chk_c), .chk_d(chk_d),
    .chk_f(chk_f)
  );

  // fibbinary nibble set {0,1,2,4,5,8,9,A} as a membership bitmap
  function automatic logic is_fib(input logic [3:0] n);
    logic [15:0] set;
    set = 16'h0737;
    return set[n];
  endfunction

  always_comb chk_f = is_fib({chk_a, chk_b, chk_c, chk_d});

  function automatic logic [3:0] ref_mask(input logic [15:0] w);
    logic [3:0] m;
    for (int i = 0; i < N; i++) m[i] = is_fib(w[4*i +: 4]);
    return m;
  endfunction

  function automatic logic [2:0] ref_count(input logic [15:0] w);
    logic [3:0] m;
    logic [2:0] c;
    m = ref_mask(w);
    c = 0;
    for (int i = 0; i < N; i++) c += 3'(m[i]);
    return c;
  endfunction

  function automatic logic ref_ok(input logic [15:0] w);
    return ((w & (w >> 1)) == 16'h0);
  endfunction

  // Caller has put start/word_in up before edge 0; mode: 0 start low,
  // 1 random start, 2 start high during SCAN. On return we are in DONE
  // and start/word_in are set to nxt_start/nxt_word.
  task automatic do_scan(input logic [15:0] w, input int mode,
                         input logic nxt_start, input logic [15:0] nxt_word);
    logic [3:0] exp_nib;
    logic [3:0] got;
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      exp_nib = w[4*(N-k) +: 4];
      got = {chk_a, chk_b, chk_c, chk_d};
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || got !== exp_nib) begin
        errors++;
        $display("FAIL scan_cycle w=%h k=%0d: busy=%b done=%b chk=%h, want busy=1 done=0 chk=%h",
                 w, k, busy, done, got, exp_nib);
      end
      checks++;
      if (nib_mask !== held_mask || nib_count !== held_count || word_ok !== held_ok) begin
        errors++;
        $display("FAIL result_hold w=%h k=%0d: mask=%b cnt=%0d ok=%b, want %b %0d %b",
                 w, k, nib_mask, nib_count, word_ok, held_mask, held_count, held_ok);
      end
      start   = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
      word_in = 16'($urandom);
    end
    @(negedge clk);
    held_mask  = ref_mask(w);
    held_count = ref_count(w);
    held_ok    = ref_ok(w);
    got = {chk_a, chk_b, chk_c, chk_d};
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || got !== 4'h0) begin
      errors++;
      $display("FAIL done_cycle w=%h: done=%b busy=%b chk=%h, want 1 0 0",
               w, done, busy, got);
    end
    checks++;
    if (nib_mask !== held_mask || nib_count !== held_count || word_ok !== held_ok) begin
      errors++;
      $display("FAIL result w=%h: mask=%b cnt=%0d ok=%b, want %b %0d %b",
               w, nib_mask, nib_count, word_ok, held_mask, held_count, held_ok);
    end
    start   = nxt_start;
    word_in = nxt_word;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {chk_a, chk_b, chk_c, chk_d} !== 4'h0 ||
        nib_mask !== held_mask || nib_count !== held_count || word_ok !== held_ok) begin
      errors++;
      $display("FAIL %s: done=%b busy=%b chk=%b mask=%b cnt=%0d ok=%b, want idle %b %0d %b",
               tag, done, busy, {chk_a, chk_b, chk_c, chk_d}, nib_mask, nib_count,
               word_ok, held_mask, held_count, held_ok);
    end
  endtask

  task automatic single(input logic [15:0] w, input int mode);
    start   = 1'b1;
    word_in = w;
    do_scan(w, mode, 1'b0, 16'($urandom));
    check_idle("after_done");
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; word_in = 16'h0;
    held_mask = 0; held_count = 0; held_ok = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) check_idle("reset_idle");
  endtask

  task automatic test_directed;
    single(16'h5555, 0);
    single(16'h1800, 0);
    single(16'h3A6F, 0);
  endtask

  task automatic test_back_to_back;
    start = 1'b1; word_in = 16'h0000;
    do_scan(16'h0000, 2, 1'b1, 16'hFFFF);
    do_scan(16'hFFFF, 2, 1'b0, 16'h1234);
    check_idle("b2b_end");
    single(16'h2525, 1);
  endtask

  task automatic test_reset_mid_scan;
    start = 1'b1; word_in = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    held_mask = 0; held_count = 0; held_ok = 0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || nib_mask !== 4'h0 || nib_count !== 3'd0 ||
        word_ok !== 1'b0 || {chk_a, chk_b, chk_c, chk_d} !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b mask=%b cnt=%0d ok=%b chk=%b, want all 0",
               busy, done, nib_mask, nib_count, word_ok, {chk_a, chk_b, chk_c, chk_d});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) check_idle("post_reset_no_done");
    single(16'h0000, 0);
  endtask

  task automatic test_random;
    logic [15:0] w;
    logic [15:0] nw;
    logic        chain;
    w = 16'($urandom);
    start = 1'b1; word_in = w;
    for (int i = 0; i < 40; i++) begin
      chain = 1'($urandom);
      nw = ($urandom_range(0, 3) == 0) ? 16'($urandom) & 16'h5555 : 16'($urandom);
      do_scan(w, $urandom_range(0, 1), chain, nw);
      if (!chain) begin
        check_idle("rand_idle");
        start = 1'b1;
        word_in = nw;
      end
      w = nw;
    end
    do_scan(w, 0, 1'b0, 16'h0);
    check_idle("rand_end");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_mid_scan;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fibb_scan_ctrl.md
# fibb_scan_ctrl

Sequencing controller that time-shares a single 4-bit fibbinary checker (`Nro_fibbinario`, inputs A..D with A the MSB, output F) across the nibbles of a wider word. It presents one nibble per cycle to the checker, collects F, checks the nibble-to-nibble boundaries itself, and reports per-nibble and whole-word results with a start/done handshake. It sits between the word source and one instance of the checker.

## Interface
- `NIBBLES`, default 4: number of nibbles per word; word width is 4*NIBBLES; minimum 2.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a scan of `word_in`; accepted only in IDLE or DONE.
- `word_in`  in  4*NIBBLES  word to scan; sampled on the accepting edge only.
- `busy`  out  1  high while in SCAN.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `nib_mask`  out  NIBBLES  bit i = nibble i (bits 4i+3..4i) is fibbinary.
- `nib_count`  out  $clog2(NIBBLES+1)  number of set bits in `nib_mask`.
- `word_ok`  out  1  whole word has no two adjacent 1s.
- `chk_a`, `chk_b`, `chk_c`, `chk_d`  out  1 each  nibble bits 3,2,1,0 driven to checker A,B,C,D.
- `chk_f`  in  1  checker result; combinational from `chk_*` in the same cycle.

## Operation
- Reset: state IDLE; `busy`, `done`, `nib_mask`, `nib_count`, `word_ok`, `chk_*` all 0; internal word, index, and accumulators cleared.
- FSM states: IDLE, SCAN, DONE.
  - IDLE, `start`=1: latch `word_in`; index := NIBBLES-1; clear accumulators (mask 0, count 0, boundary_ok 1); go to SCAN.
  - SCAN: drive `chk_*` = latched nibble[index]. On each edge: acc_mask[index] := `chk_f`; acc_count += `chk_f`. If index < NIBBLES-1 and latched bit 4*(index+1) and bit 4*index+3 are both 1, boundary_ok := 0. If index = 0, go to DONE; otherwise decrement index.
  - DONE: `done`=1 for this cycle only. `start`=1 is accepted exactly as in IDLE (back-to-back scan). Otherwise go to IDLE.
- Result outputs (`nib_mask`, `nib_count`, `word_ok`) are registers loaded on the SCAN→DONE edge. `word_ok` = (acc_mask all ones) AND boundary_ok, including the final nibble's contribution. The outputs hold their value through IDLE and through any later SCAN until the next DONE.
- `start` in SCAN is ignored. `word_in` changes outside the accepting edge have no effect.
- `chk_*` = 0 in IDLE and DONE.
- `nib_count` cannot overflow: its width holds NIBBLES.
- Fibbinary nibbles are 0, 1, 2, 4, 5, 8, 9 and A. The controller does not recompute these; it trusts `chk_f`.

## Timing
- Start accepted on edge 0. SCAN occupies cycles 1..NIBBLES, with nibble NIBBLES-1 first and nibble 0 last. `done` is high in cycle NIBBLES+1 (cycle 5 for NIBBLES=4).
- Back-to-back throughput is one word per NIBBLES+1 cycles.
- `busy` = (state == SCAN), Moore. `done` = (state == DONE), Moore.
- `chk_f` is sampled on the same edge that ends the cycle in which the nibble is driven. There are no added pipeline stages.
- Reset asserted mid-scan: immediately returns to IDLE with every output 0. The aborted scan produces no `done` and no result update.

## Test plan
- Reset then idle -> all outputs 0 and `chk_*` = 0 for 10 cycles, with `start` low.
- `word_in`=16'h5555, `start` pulse -> `chk` sequence 5,5,5,5 in cycles 1-4; `busy` high in cycles 1-4; `done` in cycle 5 with `nib_mask`=4'b1111, `nib_count`=4, `word_ok`=1.
- `word_in`=16'h1800 -> `nib_mask`=4'b1111, `nib_count`=4, `word_ok`=0 (boundary between nibbles 3 and 2).
- `word_in`=16'h3A6F -> `chk` sequence 3,A,6,F; `nib_mask`=4'b0100, `nib_count`=1, `word_ok`=0. The previous results hold until `done`.
- `start` held high continuously with `word_in`=16'h0000 then 16'hFFFF -> scans accepted at cycles 0 and 5 (in DONE). Second result: `nib_mask`=0, `nib_count`=0, `word_ok`=0. Pulses of `start` during SCAN are ignored.
- Assert `reset` in cycle 2 of a scan of 16'h5555 -> outputs 0 asynchronously, no `done`. A new scan of 16'h0000 then yields `nib_mask`=4'b1111, `word_ok`=1.
